// File: rtl/sbio_pkg.sv
// Shared definitions for the sbio link: source ids, start codes and the TX frame states.
package sbio_pkg;

  localparam int unsigned TX_SOURCE_SCAN  = 0;
  localparam int unsigned TX_SOURCE_READ  = 1;
  localparam int unsigned TX_SOURCE_OUT   = 2;

  localparam int unsigned SBIO_START_CODE = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_HEADER,
    TX_PAYLOAD
  } tx_state_e;

endpackage

// File: rtl/sbio_serializer.sv
// Frame sequencer for the sbio TX pins: start code, header, then the word LSB-first.
module sbio_serializer
  import sbio_pkg::*;
#(
  parameter int unsigned IO_BITS        = 2,
  parameter int unsigned PAYLOAD_CYCLES = 8,
  parameter int unsigned START_CODE     = SBIO_START_CODE
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load,
  input  logic [IO_BITS*PAYLOAD_CYCLES-1:0] word,
  input  logic [IO_BITS-1:0]                header,
  output logic [IO_BITS-1:0]                tx_pins,
  output logic                              busy,
  output logic                              last_cycle
);

  localparam int unsigned WORD_SIZE = IO_BITS * PAYLOAD_CYCLES;
  localparam int unsigned CNT_W     = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_CYCLES - 1);

  tx_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] shreg;
  logic [IO_BITS-1:0]   hdr;
  logic                 window;

  assign last_cycle = (state == TX_PAYLOAD) && (cnt == LAST_CNT);
  assign window     = (state == TX_IDLE) || last_cycle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      hdr     <= '0;
      tx_pins <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        TX_START: begin
          state   <= TX_HEADER;
          tx_pins <= hdr;
        end
        TX_HEADER: begin
          state   <= TX_PAYLOAD;
          cnt     <= '0;
          tx_pins <= shreg[IO_BITS-1:0];
          shreg   <= shreg >> IO_BITS;
        end
        TX_PAYLOAD: begin
          if (cnt != LAST_CNT) begin
            cnt     <= cnt + 1'b1;
            tx_pins <= shreg[IO_BITS-1:0];
            shreg   <= shreg >> IO_BITS;
          end
        end
        default: ;
      endcase
      // Idle and the last payload cycle share one path so a new frame follows with no gap.
      if (window) begin
        if (load) begin
          state   <= TX_START;
          tx_pins <= IO_BITS'(START_CODE);
          shreg   <= word;
          hdr     <= header;
          busy    <= 1'b1;
        end else begin
          state   <= TX_IDLE;
          tx_pins <= '0;
          busy    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sbio_tx_arbiter.sv
// Multi-source sbio transmitter: arbitrates word requests, tracks response credits
// and hands the winning word to the serializer.
module sbio_tx_arbiter
  import sbio_pkg::*;
#(
  parameter int unsigned            IO_BITS         = 2,
  parameter int unsigned            PAYLOAD_CYCLES  = 8,
  parameter int unsigned            NUM_SOURCES     = 3,
  parameter int unsigned            START_CODE      = SBIO_START_CODE,
  parameter int unsigned            RR_MODE         = 0,
  parameter logic [NUM_SOURCES-1:0] RSP_MASK        = NUM_SOURCES'(1 << TX_SOURCE_READ),
  parameter int unsigned            MAX_OUTSTANDING = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_SOURCES-1:0]                        req,
  input  logic [NUM_SOURCES*IO_BITS*PAYLOAD_CYCLES-1:0] data,
  output logic [NUM_SOURCES-1:0]                        ack,
  input  logic                                          rsp_done,
  output logic [IO_BITS-1:0]                            tx_pins,
  output logic                                          busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]          outstanding
);

  localparam int unsigned WORD_SIZE = IO_BITS * PAYLOAD_CYCLES;
  localparam int unsigned GW        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int unsigned CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUTSTANDING);

  logic [NUM_SOURCES-1:0] eligible;
  logic [GW-1:0]          ptr;
  logic [GW-1:0]          gnt_idx;
  logic                   found;
  logic                   grant;
  logic                   take;
  logic                   window;
  logic                   last_cycle;
  logic                   credit_full;
  logic [WORD_SIZE-1:0]   word;
  logic [IO_BITS-1:0]     header;
  int unsigned            idx;

  assign credit_full = (outstanding == CREDIT_MAX);
  assign eligible    = req & ~(RSP_MASK & {NUM_SOURCES{credit_full}});
  // Gated by reset so nothing is acked while the frame path is being cleared.
  assign window      = !reset && (!busy || last_cycle);

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned off = 0; off < NUM_SOURCES; off++) begin
      if (RR_MODE != 0) idx = (32'(ptr) + 1 + off) % NUM_SOURCES;
      else              idx = off;
      if (!found && eligible[GW'(idx)]) begin
        found   = 1'b1;
        gnt_idx = GW'(idx);
      end
    end
  end

  assign grant  = window && found;
  assign take   = grant && RSP_MASK[gnt_idx];
  assign word   = data[gnt_idx*WORD_SIZE +: WORD_SIZE];
  assign header = IO_BITS'(gnt_idx);

  always_comb begin
    ack = '0;
    if (grant) ack[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      ptr         <= GW'(NUM_SOURCES - 1);
    end else begin
      if (grant) ptr <= gnt_idx;
      if (take && !rsp_done)
        outstanding <= outstanding + 1'b1;
      else if (!take && rsp_done && outstanding != '0)
        outstanding <= outstanding - 1'b1;
    end
  end

  sbio_serializer #(
    .IO_BITS        (IO_BITS),
    .PAYLOAD_CYCLES (PAYLOAD_CYCLES),
    .START_CODE     (START_CODE)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .load       (grant),
    .word       (word),
    .header     (header),
    .tx_pins    (tx_pins),
    .busy       (busy),
    .last_cycle (last_cycle)
  );

endmodule

// File: tb/tb_sbio_tx_arbiter.sv
// Bench for sbio_tx_arbiter: a fixed-priority and a round-robin instance, each
// checked every cycle against a frame-queue model plus directed literal checks.
module tb_sbio_tx_arbiter;

  localparam int unsigned NS   = 3;
  localparam int unsigned MAXO = 2;
  localparam logic [2:0]  MASK = 3'b010;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic [2:0]  req0 = '0, req1 = '0;
  logic [47:0] data0 = '0, data1 = '0;
  logic        rsp0 = 1'b0, rsp1 = 1'b0;
  logic [2:0]  ack0, ack1;
  logic [1:0]  tx0, tx1;
  logic        busy0, busy1;
  logic [1:0]  out0, out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbio_tx_arbiter #(
    .IO_BITS(2), .PAYLOAD_CYCLES(8), .NUM_SOURCES(3), .START_CODE(1),
    .RR_MODE(0), .RSP_MASK(3'b010), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .reset(rst0), .req(req0), .data(data0), .ack(ack0),
    .rsp_done(rsp0), .tx_pins(tx0), .busy(busy0), .outstanding(out0)
  );

  sbio_tx_arbiter #(
    .IO_BITS(2), .PAYLOAD_CYCLES(8), .NUM_SOURCES(3), .START_CODE(1),
    .RR_MODE(1), .RSP_MASK(3'b010), .MAX_OUTSTANDING(2)
  ) dut_rr (
    .clk(clk), .reset(rst1), .req(req1), .data(data1), .ack(ack1),
    .rsp_done(rsp1), .tx_pins(tx1), .busy(busy1), .outstanding(out1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pin values still to appear; an empty queue means the arbiter may grant.
  int unsigned pin_q [2][$];
  int unsigned m_pins [2] = '{0, 0};
  int unsigned m_busy [2] = '{0, 0};
  int unsigned m_out  [2] = '{0, 0};
  int unsigned m_ptr  [2] = '{2, 2};

  function automatic bit elig(input int n, input int unsigned i, input logic [2:0] rq);
    return rq[i] && !(MASK[i] && m_out[n] == MAXO);
  endfunction

  task automatic model_cycle(input int n, input logic rst, input logic [2:0] rq, input logic rsp,
                             input logic [47:0] d, input logic [2:0] a, input logic [1:0] tx,
                             input logic b, input logic [1:0] o);
    int g;
    int unsigned i;
    logic [2:0] exp_ack;
    chk($sformatf("tx_pins[%0d]", n), tx, m_pins[n]);
    chk($sformatf("busy[%0d]", n), b, m_busy[n]);
    chk($sformatf("outstanding[%0d]", n), o, m_out[n]);
    g = -1;
    if (!rst && pin_q[n].size() == 0) begin
      for (int unsigned k = 0; k < NS; k++) begin
        i = (n == 1) ? (m_ptr[n] + 1 + k) % NS : k;
        if (g < 0 && elig(n, i, rq)) g = int'(i);
      end
    end
    exp_ack = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk($sformatf("ack[%0d]", n), a, exp_ack);
    if (rst) begin
      pin_q[n].delete();
      m_pins[n] = 0; m_busy[n] = 0; m_out[n] = 0; m_ptr[n] = NS - 1;
    end else begin
      if (g >= 0) begin
        pin_q[n].push_back(1);
        pin_q[n].push_back(g);
        for (int k = 0; k < 8; k++) pin_q[n].push_back(32'((d >> (g*16 + k*2)) & 48'h3));
        m_ptr[n] = g;
      end
      if (g >= 0 && MASK[g] && rsp) ;
      else if (g >= 0 && MASK[g]) m_out[n]++;
      else if (rsp && m_out[n] > 0) m_out[n]--;
      if (pin_q[n].size() > 0) begin
        m_pins[n] = pin_q[n].pop_front();
        m_busy[n] = 1;
      end else begin
        m_pins[n] = 0;
        m_busy[n] = 0;
      end
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_cycle(0, rst0, req0, rsp0, data0, ack0, tx0, busy0, out0);
      model_cycle(1, rst1, req1, rsp1, data1, ack1, tx1, busy1, out1);
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int inst, input logic [2:0] want, input int budget, output int cycles);
    logic [2:0] a;
    cycles = 0;
    @(negedge clk);
    a = (inst == 0) ? ack0 : ack1;
    while (a !== want && cycles < budget) begin
      @(negedge clk);
      cycles++;
      a = (inst == 0) ? ack0 : ack1;
    end
    chk($sformatf("ack%0d wait", inst), a, want);
  endtask

  int         a_exp [11] = '{1, 1, 3, 0, 0, 3, 1, 1, 2, 2, 0};
  logic [2:0] rr_ord [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0;

    // rsp_done with no credits in use
    rsp0 = 1'b1;
    @(negedge clk);
    chk("D ack", ack0, 3'b000);
    chk("D out", out0, 2'd0);
    next_cycle; rsp0 = 1'b0;
    @(negedge clk);
    chk("D out after", out0, 2'd0);

    // single frame from source 1
    next_cycle;
    data0[16 +: 16] = 16'hA5C3;
    req0 = 3'b010;
    wait_ack(0, 3'b010, 4, c);
    chk("A latency", c, 0);
    for (int k = 0; k < 11; k++) begin
      next_cycle;
      if (k == 0) req0 = 3'b000;
      @(negedge clk);
      chk($sformatf("A tx k=%0d", k), tx0, a_exp[k]);
      if (k == 0) chk("A out", out0, 2'd1);
      if (k == 0) chk("A busy", busy0, 1'b1);
      if (k == 10) chk("A idle", busy0, 1'b0);
    end

    // fixed priority with back-to-back frames
    next_cycle;
    data0[0 +: 16]  = 16'hC000;
    data0[32 +: 16] = 16'h5A5A;
    req0 = 3'b101;
    wait_ack(0, 3'b001, 4, c);
    next_cycle; req0 = 3'b100;
    wait_ack(0, 3'b100, 20, c);
    chk("B ack2 on last payload", c, 9);
    chk("B last chunk", tx0, 2'd3);
    next_cycle; req0 = 3'b000;
    @(negedge clk);
    chk("B start", tx0, 2'd1);
    next_cycle;
    @(negedge clk);
    chk("B header", tx0, 2'd2);
    repeat (10) next_cycle;
    next_cycle; rst0 = 1'b1;
    next_cycle; rst0 = 1'b0;

    // credits
    data0[16 +: 16] = 16'h1234;
    req0 = 3'b010;
    wait_ack(0, 3'b010, 4, c);
    next_cycle;
    wait_ack(0, 3'b010, 20, c);
    chk("C second frame back-to-back", c, 9);
    repeat (10) next_cycle;
    @(negedge clk);
    chk("C blocked ack", ack0, 3'b000);
    chk("C full", out0, 2'd2);
    next_cycle; req0 = 3'b110;
    @(negedge clk);
    chk("C skip blocked", ack0, 3'b100);
    next_cycle; req0 = 3'b010;
    next_cycle;
    next_cycle; rsp0 = 1'b1;
    @(negedge clk);
    chk("C mid-frame ack", ack0, 3'b000);
    next_cycle; rsp0 = 1'b0;
    @(negedge clk);
    chk("C returned", out0, 2'd1);
    wait_ack(0, 3'b010, 20, c);
    chk("C unblocked", c, 5);
    next_cycle;
    @(negedge clk);
    chk("C refilled", out0, 2'd2);
    next_cycle;
    next_cycle; rsp0 = 1'b1;
    next_cycle; rsp0 = 1'b0;
    @(negedge clk);
    chk("C returned again", out0, 2'd1);
    repeat (5) next_cycle;
    next_cycle; rsp0 = 1'b1;
    @(negedge clk);
    chk("C grant with rsp", ack0, 3'b010);
    next_cycle; rsp0 = 1'b0; req0 = 3'b000;
    @(negedge clk);
    chk("C simultaneous no change", out0, 2'd1);
    repeat (10) next_cycle;

    // reset mid-frame
    next_cycle; rst0 = 1'b1;
    next_cycle; rst0 = 1'b0;
    data0[16 +: 16] = 16'hA5C3;
    req0 = 3'b010;
    wait_ack(0, 3'b010, 4, c);
    next_cycle; req0 = 3'b001;
    repeat (5) next_cycle;
    next_cycle; rst0 = 1'b1;
    @(negedge clk);
    chk("E cnt4 chunk", tx0, 2'd1);
    chk("E out before", out0, 2'd1);
    next_cycle; rst0 = 1'b0;
    @(negedge clk);
    chk("E tx cleared", tx0, 2'd0);
    chk("E busy cleared", busy0, 1'b0);
    chk("E out cleared", out0, 2'd0);
    chk("E re-ack", ack0, 3'b001);
    next_cycle; req0 = 3'b000;
    repeat (12) next_cycle;

    // round robin
    rst1 = 1'b0;
    data1 = {16'h3C3C, 16'hF0F0, 16'h0F0F};
    req1 = 3'b111;
    for (int f = 0; f < 4; f++) begin
      if (f > 0) next_cycle;
      wait_ack(1, rr_ord[f], 20, c);
      chk($sformatf("RR gap %0d", f), c, (f == 0) ? 0 : 9);
    end
    next_cycle; req1 = 3'b000;
    repeat (12) next_cycle;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
